reg_access_ctrl: RTL

Initiator-side controller for the dual-read, single-write register file (16 x 32-bit). On each instruction handshake it reads Rn and Rm through read ports A and B, and presents the operands to the execute stage. It then waits for the execute result and writes it back to Rd through the register file's RW/I0 write path. It sits between the instruction decoder/ALU and register_file.

---
 rtl/reg_access_ctrl_if.sv | 50 +++++
 rtl/reg_access_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl_if.sv
// ============================================================================
// Module      : reg_access_ctrl_if
// Description : Bundles the instruction, execute-stage and register-file
//               signals of reg_access_ctrl. The slave modport is the
//               controller's view. The master modport is the view of the
//               surrounding decoder, ALU and register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface reg_access_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [ADDR_W-1:0] rn_sel;
    logic [ADDR_W-1:0] rm_sel;
    logic [ADDR_W-1:0] rd_sel;
    logic              wb_en;
    logic [DATA_W-1:0] result;
    logic              result_valid;
    logic [DATA_W-1:0] rf_A;
    logic [DATA_W-1:0] rf_B;
    logic [ADDR_W-1:0] rf_addrA;
    logic [ADDR_W-1:0] rf_addrB;
    logic [DATA_W-1:0] rf_I;
    logic              rf_RW;
    logic [DATA_W-1:0] opA;
    logic [DATA_W-1:0] opB;
    logic              op_valid;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, rn_sel, rm_sel, rd_sel, wb_en, result, result_valid,
        output rf_A, rf_B,
        input  rf_addrA, rf_addrB, rf_I, rf_RW,
        input  opA, opB, op_valid, busy, done, error
    );

    modport slave (
        input  start, rn_sel, rm_sel, rd_sel, wb_en, result, result_valid,
        input  rf_A, rf_B,
        output rf_addrA, rf_addrB, rf_I, rf_RW,
        output opA, opB, op_valid, busy, done, error
    );
endinterface

`default_nettype wire

// File: rtl/reg_access_ctrl.sv
// ============================================================================
// Module      : reg_access_ctrl
// Description : Initiator-side register access controller. For each accepted
//               instruction it reads Rn and Rm and hands the operands to the
//               execute stage. It then waits for the execute result, with a
//               bounded wait, and writes the result back to Rd.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_access_ctrl #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  wire logic         CLK,
    input  wire logic         CLR,
    reg_access_ctrl_if.slave  bus
);
    localparam int                 c_CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_rnSel;
    logic [ADDR_W-1:0]   r_rmSel;
    logic [ADDR_W-1:0]   r_rdSel;
    logic                r_wbEn;
    logic [DATA_W-1:0]   r_opA;
    logic [DATA_W-1:0]   r_opB;
    logic [DATA_W-1:0]   r_result;
    logic [c_CNT_W-1:0]  r_count;
    logic                r_timedOut;

    // The counter is compared at its registered value. It holds TIMEOUT
    // during the last EXEC cycle, so done arrives in cycle TIMEOUT+3.
    logic w_timeout;
    assign w_timeout = (r_count == c_TIMEOUT);

    // State register; reset aborts any operation, including a pending write
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode and per-state register-file / handshake outputs
    always_comb begin
        w_nextState  = r_state;
        bus.rf_addrA = '0;
        bus.rf_addrB = '0;
        bus.rf_RW    = 1'b0;
        bus.op_valid = 1'b0;
        bus.busy     = 1'b1;
        bus.done     = 1'b0;
        bus.error    = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.busy = 1'b0;
                if (bus.start) begin
                    w_nextState = S_READ;
                end
            end
            S_READ: begin
                bus.rf_addrA = r_rnSel;
                bus.rf_addrB = r_rmSel;
                w_nextState  = S_EXEC;
            end
            S_EXEC: begin
                bus.op_valid = 1'b1;
                if (bus.result_valid) begin
                    w_nextState = r_wbEn ? S_WRITE : S_DONE;
                end else if (w_timeout) begin
                    w_nextState = S_DONE;
                end
            end
            S_WRITE: begin
                bus.rf_addrA = r_rdSel;
                bus.rf_RW    = 1'b1;
                w_nextState  = S_DONE;
            end
            S_DONE: begin
                bus.done    = 1'b1;
                bus.error   = r_timedOut;
                w_nextState = S_IDLE;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Request latching, operand capture, result capture and timeout counting
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            r_rnSel    <= '0;
            r_rmSel    <= '0;
            r_rdSel    <= '0;
            r_wbEn     <= 1'b0;
            r_opA      <= '0;
            r_opB      <= '0;
            r_result   <= '0;
            r_count    <= '0;
            r_timedOut <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_rnSel    <= bus.rn_sel;
                        r_rmSel    <= bus.rm_sel;
                        r_rdSel    <= bus.rd_sel;
                        r_wbEn     <= bus.wb_en;
                        r_count    <= '0;
                        r_timedOut <= 1'b0;
                    end
                end
                S_READ: begin
                    r_opA <= bus.rf_A;
                    r_opB <= bus.rf_B;
                end
                S_EXEC: begin
                    if (bus.result_valid) begin
                        r_result <= bus.result;
                        r_count  <= '0;
                    end else if (w_timeout) begin
                        r_timedOut <= 1'b1;
                        r_count    <= '0;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.opA  = r_opA;
    assign bus.opB  = r_opB;
    assign bus.rf_I = r_result;

endmodule

`default_nettype wire
